// File: rtl/load_unit_pkg.sv
// Shared load-path definitions: RV32I load funct3 codes, FSM state encoding and
// small decode helpers used by the load sequencer.
package load_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD0  = 2'd1,
    S_RD1  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // A second word is needed only when the access runs past byte 3 of the first word.
  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    logic c;
    c = 1'b0;
    case (f3[1:0])
      2'b01:   c = (off == 2'd3);
      2'b10:   c = (off != 2'd0);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/extend.sv
// Zero/sign extender from IN_W to OUT_W bits; uext=1 selects zero extension.
// Purely combinational, no handshake.
module extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  input  logic             uext,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1] & ~uext}}, din};

endmodule

// File: rtl/load_unit.sv
// Load sequencer: one or two word reads, byte/half/word extraction and extension.
// Aligned load responds 2 cycles after accept plus ack waits; no response backpressure.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err
);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic              err_q, err_d;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_word_addr;
  logic [XLEN-1:0]   win;
  logic [XLEN-1:0]   ext8;
  logic [XLEN-1:0]   ext16;
  logic [XLEN-1:0]   result;

  assign word_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  // Natural 30-bit overflow wraps the last word of the address space back to 0.
  assign next_word_addr = {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    err_d    = err_q;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          err_d    = ~f3_legal(req_funct3);
          state_d  = f3_legal(req_funct3) ? S_RD0 : S_RESP;
        end
      end
      S_RD0: begin
        mem_rd   = 1'b1;
        mem_addr = word_addr;
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = crosses(funct3_q, addr_q[1:0]) ? S_RD1 : S_RESP;
        end
      end
      S_RD1: begin
        mem_rd   = 1'b1;
        mem_addr = next_word_addr;
        if (mem_ack) begin
          hi_d    = mem_rdata;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The window is formed from the next-state capture registers so the result
  // can be registered on the same edge that takes the last read word.
  assign win = XLEN'({hi_d, lo_d} >> {addr_q[1:0], 3'b000});

  extend #(.IN_W(8), .OUT_W(32)) u_ext8 (
    .din  (win[7:0]),
    .uext (funct3_q[2]),
    .dout (ext8)
  );

  extend #(.IN_W(16), .OUT_W(32)) u_ext16 (
    .din  (win[15:0]),
    .uext (funct3_q[2]),
    .dout (ext16)
  );

  always_comb begin
    result = win;
    case (funct3_q[1:0])
      2'b00:   result = ext8;
      2'b01:   result = ext16;
      default: result = win;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      addr_q       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      err_q        <= err_d;
      resp_valid_q <= (state_d == S_RESP);
      resp_data_q  <= (state_d == S_RESP && !err_d) ? result : '0;
      resp_err_q   <= (state_d == S_RESP) && err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
